// File: rtl/tx_fsm.sv
// ---------------------------------------------------------------------------
// tx_fsm -- transmit-side transport-layer framer (DoCE)
//
// Sits between the transaction layer and the router. Every packet accepted
// from the transaction layer is prefixed with one 16-byte MAC header beat.
// The payload beats are then forwarded untouched. A packet whose first-beat
// tuser[2] is set is consumed and silently discarded.
//
// Header beat layout (128 bits):
//   [127:116] zero, [115:112] tuser, [111:96] ETHERTYPE,
//   [95:48] destination MAC, [47:0] source MAC
//
// Ports
//   user_clk, reset_n              clock, asynchronous active-low reset
//   axi_str_*_from_trans           AXI-Stream slave from the transaction layer
//   axi_str_tready_to_trans        slave ready
//   tx_dst_mac_addr/tx_src_mac_addr MACs, sampled with the first beat
//   axi_str_*_to_router            AXI-Stream master towards the router
//   axi_str_tready_from_router     master ready
//   fsm_state_dbg                  current FSM state (IDLE=0 HEADER=1
//                                  PAYLOAD=2 DROP=3), for observation only
//   tx_pkt_cnt, tx_drop_cnt        statistics, present only with TX_STATS_EN
//
// Optional feature macro: TX_STATS_EN (adds packet / drop counters).
//
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both high. A source holds valid and its data stable until that edge.
// The router side inherits this from the transaction side during PAYLOAD and
// from the latched header registers during HEADER.
//
// DATA_WIDTH is in bytes; the header layout only fits DATA_WIDTH = 16.
// reset_n is expected to be released synchronously to user_clk by the
// surrounding reset logic.
// ---------------------------------------------------------------------------
module tx_fsm #(
    parameter int          DATA_WIDTH = 16,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5
) (
    input  logic                      user_clk,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH*8-1:0]   axi_str_tdata_from_trans,
    input  logic [DATA_WIDTH-1:0]     axi_str_tkeep_from_trans,
    input  logic                      axi_str_tvalid_from_trans,
    input  logic                      axi_str_tlast_from_trans,
    input  logic [3:0]                axi_str_tuser_from_trans,
    output logic                      axi_str_tready_to_trans,
    input  logic [47:0]               tx_dst_mac_addr,
    input  logic [47:0]               tx_src_mac_addr,
    output logic [DATA_WIDTH*8-1:0]   axi_str_tdata_to_router,
    output logic [DATA_WIDTH-1:0]     axi_str_tkeep_to_router,
    output logic                      axi_str_tvalid_to_router,
    output logic                      axi_str_tlast_to_router,
    input  logic                      axi_str_tready_from_router,
`ifdef TX_STATS_EN
    output logic [31:0]               tx_pkt_cnt,
    output logic [15:0]               tx_drop_cnt,
`endif
    output logic [1:0]                fsm_state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [47:0] dst_q, src_q;
    logic [3:0]  tuser_q;

    // Beat accepted from the transaction side / towards the router.
    logic in_fire;
    logic out_fire;

    assign in_fire  = axi_str_tvalid_from_trans & axi_str_tready_to_trans;
    assign out_fire = axi_str_tvalid_to_router & axi_str_tready_from_router;

    assign fsm_state_dbg = state_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // First beat is only inspected here; it is consumed later
                // in PAYLOAD or DROP.
                if (axi_str_tvalid_from_trans) begin
                    state_d = axi_str_tuser_from_trans[2] ? DROP : HEADER;
                end
            end
            HEADER: begin
                if (axi_str_tready_from_router) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (in_fire && axi_str_tlast_from_trans) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (in_fire && axi_str_tlast_from_trans) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and per-packet header fields.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dst_q   <= '0;
            src_q   <= '0;
            tuser_q <= '0;
        end else begin
            state_q <= state_d;
            // Sampled once per packet; later changes are ignored.
            if (state_q == IDLE && axi_str_tvalid_from_trans) begin
                dst_q   <= tx_dst_mac_addr;
                src_q   <= tx_src_mac_addr;
                tuser_q <= axi_str_tuser_from_trans;
            end
        end
    end

    // Output steering. Header content comes straight from the latched
    // registers, so it is stable for as long as the router stalls it.
    always_comb begin
        axi_str_tdata_to_router  = '0;
        axi_str_tkeep_to_router  = '0;
        axi_str_tvalid_to_router = 1'b0;
        axi_str_tlast_to_router  = 1'b0;
        axi_str_tready_to_trans  = 1'b0;
        case (state_q)
            HEADER: begin
                axi_str_tdata_to_router  = {12'd0, tuser_q, ETHERTYPE, dst_q, src_q};
                axi_str_tkeep_to_router  = '1;
                axi_str_tvalid_to_router = 1'b1;
            end
            PAYLOAD: begin
                axi_str_tdata_to_router  = axi_str_tdata_from_trans;
                axi_str_tkeep_to_router  = axi_str_tkeep_from_trans;
                axi_str_tvalid_to_router = axi_str_tvalid_from_trans;
                axi_str_tlast_to_router  = axi_str_tlast_from_trans;
                axi_str_tready_to_trans  = axi_str_tready_from_router;
            end
            DROP: begin
                axi_str_tready_to_trans  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef TX_STATS_EN
    // Header beats never carry tlast, so out_fire & tlast marks exactly one
    // event per forwarded packet. Both counters wrap naturally.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_pkt_cnt  <= '0;
            tx_drop_cnt <= '0;
        end else begin
            if (out_fire && axi_str_tlast_to_router) begin
                tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
            end
            if (state_q == DROP && in_fire && axi_str_tlast_from_trans) begin
                tx_drop_cnt <= tx_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_fsm.sv
module tb_tx_fsm;

  logic         user_clk = 1'b0;
  logic         reset_n;
  logic [127:0] tdata_in;
  logic [15:0]  tkeep_in;
  logic         tvalid_in;
  logic         tlast_in;
  logic [3:0]   tuser_in;
  logic         tready_out;
  logic [47:0]  dst;
  logic [47:0]  src;
  logic [127:0] tdata_out;
  logic [15:0]  tkeep_out;
  logic         tvalid_out;
  logic         tlast_out;
  logic         rready;
  logic [1:0]   state_dbg;
`ifdef TX_STATS_EN
  logic [31:0]  pkt_cnt;
  logic [15:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 user_clk = ~user_clk;

  tx_fsm dut (
    .user_clk                   (user_clk),
    .reset_n                    (reset_n),
    .axi_str_tdata_from_trans   (tdata_in),
    .axi_str_tkeep_from_trans   (tkeep_in),
    .axi_str_tvalid_from_trans  (tvalid_in),
    .axi_str_tlast_from_trans   (tlast_in),
    .axi_str_tuser_from_trans   (tuser_in),
    .axi_str_tready_to_trans    (tready_out),
    .tx_dst_mac_addr            (dst),
    .tx_src_mac_addr            (src),
    .axi_str_tdata_to_router    (tdata_out),
    .axi_str_tkeep_to_router    (tkeep_out),
    .axi_str_tvalid_to_router   (tvalid_out),
    .axi_str_tlast_to_router    (tlast_out),
    .axi_str_tready_from_router (rready),
`ifdef TX_STATS_EN
    .tx_pkt_cnt                 (pkt_cnt),
    .tx_drop_cnt                (drop_cnt),
`endif
    .fsm_state_dbg              (state_dbg)
  );

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d, input logic [15:0] k,
                       input logic l, input logic [3:0] u);
    tvalid_in = v;
    tdata_in  = d;
    tkeep_in  = k;
    tlast_in  = l;
    tuser_in  = u;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Router-side beat check; data/keep/last only matter while valid is high.
  task automatic chk_out(input string tag, input logic ev, input logic [127:0] ed,
                         input logic [15:0] ek, input logic el, input logic er);
    #1;
    chk({tag, ".valid"}, 128'(tvalid_out), 128'(ev));
    chk({tag, ".tready"}, 128'(tready_out), 128'(er));
    if (ev) begin
      chk({tag, ".data"}, tdata_out, ed);
      chk({tag, ".keep"}, 128'(tkeep_out), 128'(ek));
      chk({tag, ".last"}, 128'(tlast_out), 128'(el));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rready  = 1'b1;
    dst     = '0;
    src     = 48'h112233445566;
    drive(1'b0, '0, '0, 1'b0, 4'h0);

    // Reset state
    #12;
    chk_out("reset", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("reset.data", tdata_out, '0);
    chk("reset.state", 128'(state_dbg), 128'd0);
    step();
    reset_n = 1'b1;

    // 1: 3-beat packet, router always ready
    dst = 48'h0A0B0C0D0E0F;
    drive(1'b1, 128'hD1D1_0001_D1D1_0001_D1D1_0001_D1D1_0001, 16'hFFFF, 1'b0, 4'h1);
    chk_out("t1_idle", 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    chk_out("t1_hdr", 1'b1, 128'h0001_88B5_0A0B_0C0D_0E0F_1122_3344_5566, 16'hFFFF, 1'b0, 1'b0);
    step();
    chk_out("t1_b1", 1'b1, 128'hD1D1_0001_D1D1_0001_D1D1_0001_D1D1_0001, 16'hFFFF, 1'b0, 1'b1);
    step();
    dst = 48'hFFFF_FFFF_FFFF; // mid-packet changes must be ignored
    drive(1'b1, 128'hD2D2_0002_D2D2_0002_D2D2_0002_D2D2_0002, 16'hFFFF, 1'b0, 4'h4);
    chk_out("t1_b2", 1'b1, 128'hD2D2_0002_D2D2_0002_D2D2_0002_D2D2_0002, 16'hFFFF, 1'b0, 1'b1);
    step();
    drive(1'b1, 128'hD3D3_0003_D3D3_0003_D3D3_0003_D3D3_0003, 16'hFFFF, 1'b1, 4'h4);
    chk_out("t1_b3", 1'b1, 128'hD3D3_0003_D3D3_0003_D3D3_0003_D3D3_0003, 16'hFFFF, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 4'h0);
    chk_out("t1_end", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("t1_end.state", 128'(state_dbg), 128'd0);

    // 2: single-beat packet with partial keep
    dst = 48'hAABBCCDDEEFF;
    drive(1'b1, 128'h0000_0000_0000_0000_C0DE_C0DE_C0DE_C0DE, 16'h00FF, 1'b1, 4'h0);
    chk_out("t2_idle", 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    chk_out("t2_hdr", 1'b1, 128'h0000_88B5_AABB_CCDD_EEFF_1122_3344_5566, 16'hFFFF, 1'b0, 1'b0);
    step();
    chk_out("t2_b1", 1'b1, 128'h0000_0000_0000_0000_C0DE_C0DE_C0DE_C0DE, 16'h00FF, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 4'h0);
    chk_out("t2_end", 1'b0, '0, '0, 1'b0, 1'b0);

    // 3: dropped 5-beat packet
    drive(1'b1, 128'hDEAD_0001, 16'hFFFF, 1'b0, 4'h4);
    chk_out("t3_idle", 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    chk_out("t3_d1", 1'b0, '0, '0, 1'b0, 1'b1);
    chk("t3_d1.state", 128'(state_dbg), 128'd3);
    for (int i = 2; i <= 5; i++) begin
      step();
      drive(1'b1, 128'(32'hDEAD_0000 + i), 16'hFFFF, (i == 5), 4'h0);
      chk_out($sformatf("t3_d%0d", i), 1'b0, '0, '0, 1'b0, 1'b1);
    end
    step();
    drive(1'b0, '0, '0, 1'b0, 4'h0);
    chk_out("t3_end", 1'b0, '0, '0, 1'b0, 1'b0);
`ifdef TX_STATS_EN
    chk("t3_drop_cnt", 128'(drop_cnt), 128'd1);
    chk("t3_pkt_cnt", 128'(pkt_cnt), 128'd2);
`endif

    // 4: router stalls during header and beat 2, input valid gap before beat 3
    dst = 48'h000000000001;
    drive(1'b1, 128'hE1E1_E1E1, 16'hFFFF, 1'b0, 4'h2);
    chk_out("t4_idle", 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    rready = 1'b0;
    chk_out("t4_hdr_s0", 1'b1, 128'h0002_88B5_0000_0000_0001_1122_3344_5566, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_out($sformatf("t4_hdr_s%0d", i), 1'b1, 128'h0002_88B5_0000_0000_0001_1122_3344_5566,
              16'hFFFF, 1'b0, 1'b0);
    end
    rready = 1'b1;
    chk_out("t4_hdr_go", 1'b1, 128'h0002_88B5_0000_0000_0001_1122_3344_5566, 16'hFFFF, 1'b0, 1'b0);
    step();
    chk_out("t4_b1", 1'b1, 128'hE1E1_E1E1, 16'hFFFF, 1'b0, 1'b1);
    step();
    drive(1'b1, 128'hE2E2_E2E2, 16'hFFFF, 1'b0, 4'h0);
    rready = 1'b0;
    chk_out("t4_b2_s0", 1'b1, 128'hE2E2_E2E2, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_out($sformatf("t4_b2_s%0d", i), 1'b1, 128'hE2E2_E2E2, 16'hFFFF, 1'b0, 1'b0);
    end
    rready = 1'b1;
    chk_out("t4_b2_go", 1'b1, 128'hE2E2_E2E2, 16'hFFFF, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 4'h0);
    chk_out("t4_gap0", 1'b0, '0, '0, 1'b0, 1'b1);
    step();
    chk_out("t4_gap1", 1'b0, '0, '0, 1'b0, 1'b1);
    chk("t4_gap1.state", 128'(state_dbg), 128'd2);
    drive(1'b1, 128'hE3E3_E3E3, 16'h0F0F, 1'b1, 4'h0);
    chk_out("t4_b3", 1'b1, 128'hE3E3_E3E3, 16'h0F0F, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 4'h0);
    chk_out("t4_end", 1'b0, '0, '0, 1'b0, 1'b0);

    // 5: reset during beat 2, then a fresh packet
    dst = 48'h000000000005;
    drive(1'b1, 128'hF1F1, 16'hFFFF, 1'b0, 4'h0);
    chk_out("t5_idle", 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    chk_out("t5_hdr", 1'b1, 128'h0000_88B5_0000_0000_0005_1122_3344_5566, 16'hFFFF, 1'b0, 1'b0);
    step();
    chk_out("t5_b1", 1'b1, 128'hF1F1, 16'hFFFF, 1'b0, 1'b1);
    step();
    drive(1'b1, 128'hF2F2, 16'hFFFF, 1'b0, 4'h0);
    chk_out("t5_b2", 1'b1, 128'hF2F2, 16'hFFFF, 1'b0, 1'b1);
    reset_n = 1'b0;
    chk_out("t5_rst", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("t5_rst.data", tdata_out, '0);
    chk("t5_rst.keep", 128'(tkeep_out), 128'd0);
    chk("t5_rst.state", 128'(state_dbg), 128'd0);
`ifdef TX_STATS_EN
    chk("t5_rst.pkt_cnt", 128'(pkt_cnt), 128'd0);
`endif
    step();
    reset_n = 1'b1;
    dst = 48'h000000000006;
    drive(1'b1, 128'hF3F3, 16'hFFFF, 1'b1, 4'h1);
    chk_out("t5_idle2", 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    chk_out("t5_hdr2", 1'b1, 128'h0001_88B5_0000_0000_0006_1122_3344_5566, 16'hFFFF, 1'b0, 1'b0);
    step();
    chk_out("t5_b3", 1'b1, 128'hF3F3, 16'hFFFF, 1'b1, 1'b1);
    step();

    // 6: back-to-back 2-beat packets, mandatory IDLE between
    dst = 48'h0000000000A1;
    drive(1'b1, 128'hA1A1_0001, 16'hFFFF, 1'b0, 4'h0);
    chk_out("t6_idleA", 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    chk_out("t6_hdrA", 1'b1, 128'h0000_88B5_0000_0000_00A1_1122_3344_5566, 16'hFFFF, 1'b0, 1'b0);
    step();
    chk_out("t6_A1", 1'b1, 128'hA1A1_0001, 16'hFFFF, 1'b0, 1'b1);
    step();
    drive(1'b1, 128'hA1A1_0002, 16'hFFFF, 1'b1, 4'h0);
    chk_out("t6_A2", 1'b1, 128'hA1A1_0002, 16'hFFFF, 1'b1, 1'b1);
    step();
    dst = 48'h0000000000B2;
    drive(1'b1, 128'hB2B2_0001, 16'hFFFF, 1'b0, 4'h0);
    chk_out("t6_idleB", 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    chk_out("t6_hdrB", 1'b1, 128'h0000_88B5_0000_0000_00B2_1122_3344_5566, 16'hFFFF, 1'b0, 1'b0);
    step();
    chk_out("t6_B1", 1'b1, 128'hB2B2_0001, 16'hFFFF, 1'b0, 1'b1);
    step();
    drive(1'b1, 128'hB2B2_0002, 16'hFFFF, 1'b1, 4'h0);
    chk_out("t6_B2", 1'b1, 128'hB2B2_0002, 16'hFFFF, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 4'h0);
    chk_out("t6_end", 1'b0, '0, '0, 1'b0, 1'b0);
`ifdef TX_STATS_EN
    chk("t6_pkt_cnt", 128'(pkt_cnt), 128'd3);
    chk("t6_drop_cnt", 128'(drop_cnt), 128'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
